// File: rtl/addr8s_chk_pkg.sv
// ---------------------------------------------------------------------------
// addr8s_chk_pkg
//   Shared types and helpers for the addr8s residue checker.
//   - res3_t  : a mod-3 residue, always holding 0..2
//   - state_t : checker FSM states (RUN, ALARM)
//   - OUT_W   : width of the adder result being checked
//   - mod3()  : sign-corrected residue, (u - corr) mod 3
//   - add3()  : residue addition, (x + y) mod 3
// ---------------------------------------------------------------------------
package addr8s_chk_pkg;

    typedef logic [1:0] res3_t;

    typedef enum logic {
        RUN   = 1'b0,
        ALARM = 1'b1
    } state_t;

    localparam int OUT_W = 9;

    // u is the residue of the unsigned reading, corr is the residue of the
    // weight removed by the sign bit. Both are in 0..2, so u + 3 - corr lies
    // in 1..5 and one conditional subtract brings it back to 0..2.
    function automatic res3_t mod3(input res3_t u, input res3_t corr);
        logic [2:0] t;
        t = {1'b0, u} + 3'd3 - {1'b0, corr};
        if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return t[1:0];
    endfunction

    function automatic res3_t add3(input res3_t x, input res3_t y);
        logic [2:0] t;
        t = {1'b0, x} + {1'b0, y};
        if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/addr8s_mod3_residue.sv
// ---------------------------------------------------------------------------
// addr8s_mod3_residue
//   Combinational mod-3 residue of a W-bit two's complement value.
//   Ports:
//     x  in  [W-1:0]  two's complement value
//     r  out [1:0]    residue of x, 0..2
//   The signed value is u(x) - x[W-1] * 2^W. Since 2^W mod 3 is 1 for even W
//   and 2 for odd W, the sign bit only subtracts a constant residue.
// ---------------------------------------------------------------------------
module addr8s_mod3_residue
    import addr8s_chk_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [1:0]   r
);

    localparam res3_t WRAP = (W % 2 == 0) ? 2'd1 : 2'd2;
    localparam logic [W-1:0] THREE = W'(3);

    logic [W-1:0] u_mod;
    res3_t        corr;

    always_comb begin
        u_mod = x % THREE;
        corr  = x[W-1] ? WRAP : 2'd0;
        r     = mod3(u_mod[1:0], corr);
    end

endmodule

// File: rtl/addr8s_residue_checker.sv
// ---------------------------------------------------------------------------
// addr8s_residue_checker
//   Concurrent error detector for the 8-bit signed adder. Each accepted
//   triple (a, b, sum) is reduced to mod-3 residues in stage 1; stage 2
//   checks res(a) + res(b) == res(sum), counts mismatches and drives a
//   sticky alarm after ALARM_THRESH consecutive mismatches.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     in_valid/in_ready input handshake for the triple a, b, sum
//     out_valid/out_ready output handshake for err, err_cnt (and exact_err)
//     err               residue mismatch for the presented result
//     err_cnt           saturating count of mismatches since reset
//     alarm             high while the FSM is in ALARM
//     clr_alarm         pulse: return to RUN and zero the run counter
//     exact_err         (ADDR8S_EXACT_CHECK_EN only) sum != a + b
//     dbg_state         current FSM state (0 = RUN, 1 = ALARM)
//
//   Build option: define ADDR8S_EXACT_CHECK_EN to add the exact-sum check,
//   which also feeds the counters.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. The output side holds out_valid, err, err_cnt (and exact_err)
//   stable while out_valid && !out_ready; in_ready is low only when both
//   stages are full and the output is stalled, so nothing is overwritten.
// ---------------------------------------------------------------------------
module addr8s_residue_checker
    import addr8s_chk_pkg::*;
#(
    parameter int ALARM_THRESH = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [8:0]       sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             alarm,
`ifdef ADDR8S_EXACT_CHECK_EN
    output logic             exact_err,
`endif
    input  logic             clr_alarm,
    output logic             dbg_state
);

    localparam logic [3:0] THRESH = 4'(ALARM_THRESH);

    // Residue units
    res3_t ra_c, rb_c, ro_c;

    addr8s_mod3_residue #(.W(8))     u_res_a (.x(a),   .r(ra_c));
    addr8s_mod3_residue #(.W(8))     u_res_b (.x(b),   .r(rb_c));
    addr8s_mod3_residue #(.W(OUT_W)) u_res_o (.x(sum), .r(ro_c));

    // Stage 1 registers
    logic  s1_full;
    res3_t s1_ra, s1_rb, s1_ro;
`ifdef ADDR8S_EXACT_CHECK_EN
    logic [8:0] s1_exact;
    logic [8:0] s1_sum;
`endif

    // Stage 2 / FSM state
    logic [3:0] run_cnt;
    state_t     state;

    logic       in_fire;
    logic       s2_load;
    logic       err_nxt;
    logic       exact_nxt;
    logic       hit;
    logic [3:0] run_nxt;
    logic       thresh_hit;

    // Stage 2 is free when empty or draining this cycle.
    assign in_ready  = !s1_full || !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign s2_load   = s1_full && (!out_valid || out_ready);
    assign dbg_state = (state == ALARM);

    always_comb begin
        err_nxt   = (add3(s1_ra, s1_rb) != s1_ro);
`ifdef ADDR8S_EXACT_CHECK_EN
        exact_nxt = (s1_sum != s1_exact);
`else
        exact_nxt = 1'b0;
`endif
        hit        = err_nxt || exact_nxt;
        run_nxt    = 4'd0;
        if (hit) begin
            run_nxt = (run_cnt == 4'd15) ? 4'd15 : run_cnt + 4'd1;
        end
        thresh_hit = (run_nxt >= THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_full  <= 1'b0;
            s1_ra    <= 2'd0;
            s1_rb    <= 2'd0;
            s1_ro    <= 2'd0;
`ifdef ADDR8S_EXACT_CHECK_EN
            s1_exact <= 9'd0;
            s1_sum   <= 9'd0;
`endif
        end else if (in_fire) begin
            s1_full  <= 1'b1;
            s1_ra    <= ra_c;
            s1_rb    <= rb_c;
            s1_ro    <= ro_c;
`ifdef ADDR8S_EXACT_CHECK_EN
            s1_exact <= {a[7], a} + {b[7], b};
            s1_sum   <= sum;
`endif
        end else if (s2_load) begin
            s1_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
`ifdef ADDR8S_EXACT_CHECK_EN
            exact_err <= 1'b0;
`endif
            err_cnt   <= '0;
            run_cnt   <= 4'd0;
            state     <= RUN;
            alarm     <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                err       <= err_nxt;
`ifdef ADDR8S_EXACT_CHECK_EN
                exact_err <= exact_nxt;
`endif
                if (hit && (err_cnt != {CNT_W{1'b1}})) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // clr_alarm takes priority over any threshold crossing; an error
            // loading in the same cycle still counts as the first of a new run.
            if (clr_alarm) begin
                state   <= RUN;
                alarm   <= 1'b0;
                run_cnt <= (s2_load && hit) ? 4'd1 : 4'd0;
            end else if (s2_load) begin
                run_cnt <= run_nxt;
                case (state)
                    RUN: begin
                        if (thresh_hit) begin
                            state <= ALARM;
                            alarm <= 1'b1;
                        end
                    end
                    ALARM: begin
                        state <= ALARM;
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addr8s_residue_checker.sv
module tb_addr8s_residue_checker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [8:0]  sum;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [15:0] err_cnt;
    logic        alarm;
    logic        clr_alarm;
    logic        dbg_state;
`ifdef ADDR8S_EXACT_CHECK_EN
    logic        exact_err;
`endif

    int checks;
    int errors;

    logic [0:0] exp_q[$];

    addr8s_residue_checker #(.ALARM_THRESH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt),
        .alarm     (alarm),
`ifdef ADDR8S_EXACT_CHECK_EN
        .exact_err (exact_err),
`endif
        .clr_alarm (clr_alarm),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // driver: called just after a rising edge, returns just after the
    // rising edge on which the triple was accepted
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [8:0] ts);
        int n;
        a        = ta;
        b        = tb;
        sum      = ts;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // one transaction with out_ready high; optional clr_alarm pulse in the
    // cycle where the result loads into stage 2
    task automatic run1(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [8:0] ts, input logic e_err, input logic e_exact,
                        input int e_cnt, input logic e_alarm, input logic clr_at_load,
                        output int lat);
        send(ta, tb, ts);
        if (clr_at_load) begin
            clr_alarm = 1'b1;
            @(posedge clk);
            #1;
            clr_alarm = 1'b0;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_err"}, err, e_err);
        chk({tag, "_cnt"}, err_cnt, e_cnt);
        chk({tag, "_alarm"}, alarm, e_alarm);
`ifdef ADDR8S_EXACT_CHECK_EN
        chk({tag, "_exact"}, exact_err, e_exact);
`else
        if (e_exact) begin end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         lat;
        int         got;
        int         n;
        int         cnt_model;
        logic [0:0] e;
        logic [7:0] pa[8];
        logic [7:0] pb[8];
        logic [8:0] ps[8];
        logic [7:0] pat;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        sum       = 9'h000;
        out_ready = 1'b1;
        clr_alarm = 1'b0;

        // reset state
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // directed residue checks
        run1("t1", 8'h05, 8'h03, 9'h008, 0, 0, 0, 0, 0, lat);
        chk("t1_latency", lat, 2);
        run1("t2", 8'h80, 8'hFF, 9'h17F, 0, 0, 0, 0, 0, lat);
        run1("t3", 8'h7F, 8'h7F, 9'h0FE, 0, 0, 0, 0, 0, lat);
        run1("t4", 8'h05, 8'h03, 9'h009, 1, 1, 1, 0, 0, lat);
`ifdef ADDR8S_EXACT_CHECK_EN
        run1("t5", 8'h05, 8'h03, 9'h00B, 0, 1, 2, 0, 0, lat);
        run1("t6", 8'h05, 8'h03, 9'h008, 0, 0, 2, 0, 0, lat);
`else
        run1("t5", 8'h05, 8'h03, 9'h00B, 0, 1, 1, 0, 0, lat);
        run1("t6", 8'h05, 8'h03, 9'h008, 0, 0, 1, 0, 0, lat);
`endif

        // alarm after four consecutive faults, then clear
        do_reset();
        chk("rst2_cnt", err_cnt, 0);
        run1("al1", 8'h05, 8'h03, 9'h009, 1, 1, 1, 0, 0, lat);
        run1("al2", 8'h05, 8'h03, 9'h009, 1, 1, 2, 0, 0, lat);
        run1("al3", 8'h05, 8'h03, 9'h009, 1, 1, 3, 0, 0, lat);
        run1("al4", 8'h05, 8'h03, 9'h009, 1, 1, 4, 1, 0, lat);
        chk("al4_state", dbg_state, 1);
        clr_alarm = 1'b1;
        @(posedge clk);
        #1;
        clr_alarm = 1'b0;
        @(negedge clk);
        chk("clr_alarm", alarm, 0);
        chk("clr_state", dbg_state, 0);
        chk("clr_cnt", err_cnt, 4);
        @(posedge clk);
        #1;

        // clr_alarm coinciding with the threshold-reaching fault
        run1("cw1", 8'h05, 8'h03, 9'h009, 1, 1, 5, 0, 0, lat);
        run1("cw2", 8'h05, 8'h03, 9'h009, 1, 1, 6, 0, 0, lat);
        run1("cw3", 8'h05, 8'h03, 9'h009, 1, 1, 7, 0, 0, lat);
        run1("cw4", 8'h05, 8'h03, 9'h009, 1, 1, 8, 0, 1, lat);
        run1("cw5", 8'h05, 8'h03, 9'h009, 1, 1, 9, 0, 0, lat);
        run1("cw6", 8'h05, 8'h03, 9'h009, 1, 1, 10, 0, 0, lat);
        run1("cw7", 8'h05, 8'h03, 9'h009, 1, 1, 11, 1, 0, lat);

        // stalled stream, in-order delivery
        do_reset();
        pat = 8'b1001_0110; // bit i = expected err of triple i
        for (int i = 0; i < 8; i++) begin
            if (pat[i]) begin
                pa[i] = (i % 2 == 0) ? 8'h05 : 8'h7F;
                pb[i] = (i % 2 == 0) ? 8'h03 : 8'h7F;
                ps[i] = (i % 2 == 0) ? 9'h009 : 9'h0FF;
            end else begin
                pa[i] = (i % 2 == 0) ? 8'h05 : 8'h80;
                pb[i] = (i % 2 == 0) ? 8'h03 : 8'hFF;
                ps[i] = (i % 2 == 0) ? 9'h008 : 9'h17F;
            end
            exp_q.push_back(pat[i]);
        end
        out_ready = 1'b0;
        send(pa[0], pb[0], ps[0]);
        send(pa[1], pb[1], ps[1]);
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        a        = pa[2];
        b        = pb[2];
        sum      = ps[2];
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", in_ready, 0);
            chk("stall_err_stable", err, pat[0]);
        end
        @(posedge clk);
        #1;
        got       = 0;
        cnt_model = 0;
        fork
            begin
                out_ready = 1'b1;
                for (int i = 2; i < 8; i++) begin
                    send(pa[i], pb[i], ps[i]);
                end
            end
            begin
                n = 0;
                while (got < 8 && n < 100) begin
                    @(negedge clk);
                    n++;
                    if (out_valid && out_ready) begin
                        e = exp_q.pop_front();
                        if (e == 1'b1) cnt_model++;
                        chk("stream_err", err, e);
                        chk("stream_cnt", err_cnt, cnt_model);
                        got++;
                    end
                end
            end
        join
        chk("stream_count", got, 8);
        repeat (4) @(negedge clk);
        chk("stream_no_dup", out_valid, 0);
        chk("stream_total", err_cnt, 4);

        // reset with both stages full
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send(8'h05, 8'h03, 9'h009);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_alarm", alarm, 1);
        out_ready = 1'b0;
        send(8'h05, 8'h03, 9'h009);
        send(8'h05, 8'h03, 9'h009);
        chk("pre_rst_full", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_cnt", err_cnt, 0);
        chk("async_alarm", alarm, 0);
        chk("async_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
